// File: rtl/hall_call_encoder_pkg.sv
// hall_call_encoder_pkg: floor index type and widths shared with
// the scheduler, call FIFO and car FSM.
package hall_call_encoder_pkg;

  localparam int FLOOR_W  = 4;
  localparam int DB_CNT_W = 8;

  typedef logic [FLOOR_W-1:0] floor_t;

  // Next floor index, wrapping from n-1 back to 0.
  function automatic floor_t wrap_inc(
    input floor_t f,
    input int     n
  );
    if (int'(f) >= n - 1) begin
      return '0;
    end
    return f + floor_t'(1);
  endfunction

endpackage

// File: rtl/hall_call_encoder_call_debouncer.sv
// call_debouncer: one hall button -> 2-flop sync, debounce, rise pulse.
// Ports: clk, rst (async active-low), btn (raw), rise (1-cycle pulse).
module call_debouncer
  import hall_call_encoder_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] DB_LAST =
    DB_CNT_W'(DB_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                level;
  logic [DB_CNT_W-1:0] cnt;

  // The rise pulse is registered alongside the level change so the
  // parent sees it exactly one cycle after the level goes high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hall_call_encoder.sv
// hall_call_encoder: debounced hall calls -> pending lamps + req pulses.
// Ports: clk, rst, btn, floor_l1/2 in; req_valid, req_new, pending out.
module hall_call_encoder
  import hall_call_encoder_pkg::*;
#(
  parameter int NUM_FLOORS = 16,
  parameter int DB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn,
  input  floor_t                floor_l1,
  input  floor_t                floor_l2,
  output logic                  req_valid,
  output floor_t                req_new,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int IDX_W = FLOOR_W + 1;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] issued;
  logic [NUM_FLOORS-1:0] at_car;
  logic [NUM_FLOORS-1:0] cand;
  logic [NUM_FLOORS-1:0] grant;
  logic [IDX_W-1:0]      slot;
  floor_t                ptr;
  floor_t                pick;
  logic                  found;

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_db
    call_debouncer #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .btn (btn[f]),
      .rise(rise[f])
    );
  end

  // Car positions >= NUM_FLOORS match no index and clear nothing.
  always_comb begin
    at_car = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      at_car[f] = (floor_l1 == floor_t'(f)) ||
                  (floor_l2 == floor_t'(f));
    end
  end

  assign cand = pending & ~issued & ~at_car;

  // Round-robin search from ptr, wrapping at NUM_FLOORS-1.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    slot  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      slot = {1'b0, ptr} + IDX_W'(i);
      if (slot >= IDX_W'(NUM_FLOORS)) begin
        slot = slot - IDX_W'(NUM_FLOORS);
      end
      if (!found && cand[slot[FLOOR_W-1:0]]) begin
        found = 1'b1;
        pick  = slot[FLOOR_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) begin
      grant[pick] = 1'b1;
    end
  end

  // Clear wins over set: a press at an occupied floor never latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_valid <= 1'b0;
      req_new   <= '0;
      pending   <= '0;
      issued    <= '0;
      ptr       <= '0;
    end else begin
      req_valid <= found;
      if (found) begin
        req_new <= pick;
        ptr     <= wrap_inc(pick, NUM_FLOORS);
      end
      pending <= (pending | rise) & ~at_car;
      issued  <= (issued | grant) & ~at_car;
    end
  end

endmodule

// File: tb/tb_hall_call_encoder.sv
// tb_hall_call_encoder: vector table, directed corner sequences and a
// randomized run against a behavioural model of the hall call encoder.
module tb_hall_call_encoder;
  import hall_call_encoder_pkg::*;

  localparam int N  = 16;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  btn = '0;
  floor_t        f1  = '0;
  floor_t        f2  = '0;
  logic          req_valid;
  floor_t        req_new;
  logic [N-1:0]  pending;

  int n_cmp = 0;
  int n_bad = 0;

  hall_call_encoder #(
    .NUM_FLOORS(N),
    .DB_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .floor_l1 (f1),
    .floor_l2 (f2),
    .req_valid(req_valid),
    .req_new  (req_new),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    btn = '0;
    f1  = '0;
    f2  = '0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // ---------------- behavioural reference model ----------------
  bit [N-1:0]  m_s1, m_s2, m_lvl, m_rise, m_pend, m_iss;
  bit [DB-1:0] m_hist [N];
  int          m_nsamp[N];
  int          m_ptr;
  bit          m_valid;
  int          m_new;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
    m_pend = '0; m_iss = '0;
    m_ptr = 0; m_valid = 0; m_new = 0;
    for (int f = 0; f < N; f++) begin
      m_hist[f]  = '0;
      m_nsamp[f] = 0;
    end
  endtask

  // State after the coming clock edge, from current state + inputs.
  task automatic model_step();
    bit [N-1:0] at, cand, grant, n_lvl, n_rise;
    bit         flip;
    int         best, bestd, d;
    at = '0;
    for (int f = 0; f < N; f++)
      at[f] = (int'(f1) == f) || (int'(f2) == f);
    cand  = m_pend & ~m_iss & ~at;
    best  = -1;
    bestd = N;
    for (int f = 0; f < N; f++) begin
      if (cand[f]) begin
        d = (f - m_ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = f;
        end
      end
    end
    grant = '0;
    if (best >= 0) grant[best] = 1'b1;
    // Level flips once the last DB samples all disagree with it.
    for (int f = 0; f < N; f++) begin
      m_hist[f] = {m_hist[f][DB-2:0], m_s2[f]};
      if (m_nsamp[f] < DB) m_nsamp[f]++;
      flip = (m_nsamp[f] >= DB) &&
             (m_hist[f] == {DB{~m_lvl[f]}});
      n_lvl[f]  = flip ? ~m_lvl[f] : m_lvl[f];
      n_rise[f] = flip && !m_lvl[f];
    end
    m_pend  = (m_pend | m_rise) & ~at;
    m_iss   = (m_iss | grant) & ~at;
    m_valid = (best >= 0);
    if (m_valid) begin
      m_new = best;
      m_ptr = (best + 1) % N;
    end
    m_s2   = m_s1;
    m_s1   = btn;
    m_lvl  = n_lvl;
    m_rise = n_rise;
  endtask

  // ---------------- single-press vector table ----------------
  typedef struct {
    int         fl;
    int         c1;
    int         c2;
    logic [N-1:0] exp_pend;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int seen_v, seen_p;

    // Reset holds everything at zero even with all buttons high.
    rst = 1'b0;
    btn = '1;
    tick(3);
    chk("rst_valid", req_valid, 0);
    chk("rst_new", req_new, 0);
    chk("rst_pending", pending, 0);
    rst = 1'b1;
    btn = '0;
    seen_v = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen_v += req_valid;
    end
    chk("idle_no_valid", seen_v, 0);

    tbl[0] = '{5,  0, 0,  16'h0020, 1'b1};
    tbl[1] = '{0,  3, 4,  16'h0001, 1'b1};
    tbl[2] = '{15, 0, 0,  16'h8000, 1'b1};
    tbl[3] = '{7,  7, 1,  16'h0000, 1'b0};
    tbl[4] = '{12, 2, 12, 16'h0000, 1'b0};

    for (int t = 0; t < 5; t++) begin
      do_reset();
      f1 = floor_t'(tbl[t].c1);
      f2 = floor_t'(tbl[t].c2);
      btn[tbl[t].fl] = 1'b1;
      tick(6);
      chk($sformatf("v%0d_pend_e5", t), pending, 0);
      tick(1);
      chk($sformatf("v%0d_pend_e6", t), pending, tbl[t].exp_pend);
      chk($sformatf("v%0d_valid_e6", t), req_valid, 0);
      tick(1);
      chk($sformatf("v%0d_valid_e7", t), req_valid, tbl[t].exp_valid);
      if (tbl[t].exp_valid)
        chk($sformatf("v%0d_new_e7", t), req_new, tbl[t].fl);
      seen_v = 0;
      for (int i = 0; i < 6; i++) begin
        tick(1);
        seen_v += req_valid;
      end
      chk($sformatf("v%0d_no_reissue", t), seen_v, 0);
      chk($sformatf("v%0d_pend_hold", t), pending, tbl[t].exp_pend);
    end

    // Glitch of 3 samples is rejected; exactly 4 is accepted.
    do_reset();
    btn[3] = 1'b1;
    tick(3);
    btn[3] = 1'b0;
    seen_v = 0; seen_p = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen_v += req_valid;
      seen_p += pending[3];
    end
    chk("glitch3_pend", seen_p, 0);
    chk("glitch3_valid", seen_v, 0);
    btn[3] = 1'b1;
    tick(4);
    btn[3] = 1'b0;
    seen_p = 0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      seen_p += pending[3];
    end
    chk("press4_pend", seen_p > 0, 1);

    // Retire, re-press, and press at an occupied floor.
    do_reset();
    btn[5] = 1'b1;
    tick(8);
    chk("rp_valid1", req_valid, 1);
    chk("rp_new1", req_new, 5);
    tick(1);
    chk("rp_pulse_one", req_valid, 0);
    f2 = 4'd5;
    tick(1);
    chk("rp_retired", pending[5], 0);
    f2 = 4'd0;
    btn[5] = 1'b0;
    tick(10);
    btn[5] = 1'b1;
    tick(8);
    chk("rp_valid2", req_valid, 1);
    chk("rp_new2", req_new, 5);
    f1 = 4'd5;
    tick(1);
    btn[5] = 1'b0;
    tick(10);
    btn[5] = 1'b1;
    seen_v = 0; seen_p = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      seen_v += req_valid;
      seen_p += pending[5];
    end
    chk("car_at_pend", seen_p, 0);
    chk("car_at_valid", seen_v, 0);
    f1 = 4'd0;
    tick(4);
    chk("car_left_pend", pending, 0);

    // Round-robin from pointer 10: expect 14, 2, 9.
    do_reset();
    btn[9] = 1'b1;
    tick(8);
    chk("rr_first", req_new, 9);
    f2 = 4'd9;
    tick(1);
    btn = '0;
    f2  = 4'd0;
    tick(10);
    btn = 16'h4204;
    tick(8);
    chk("rr_v0", req_valid, 1);
    chk("rr_n0", req_new, 14);
    tick(1);
    chk("rr_v1", req_valid, 1);
    chk("rr_n1", req_new, 2);
    tick(1);
    chk("rr_v2", req_valid, 1);
    chk("rr_n2", req_new, 9);
    tick(1);
    chk("rr_v3", req_valid, 0);

    // Reset mid-operation drops pending and issued calls.
    do_reset();
    btn = 16'h0104;
    tick(10);
    chk("mr_pend", pending, 16'h0104);
    rst = 1'b0;
    btn = '0;
    #1;
    chk("mr_async_pend", pending, 0);
    chk("mr_async_valid", req_valid, 0);
    tick(1);
    rst = 1'b1;
    seen_v = 0; seen_p = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      seen_v += req_valid;
      seen_p += (pending != 0);
    end
    chk("mr_quiet_valid", seen_v, 0);
    chk("mr_quiet_pend", seen_p, 0);
    btn[8] = 1'b1;
    tick(8);
    chk("mr_new_valid", req_valid, 1);
    chk("mr_new_floor", req_new, 8);

    // Randomized run against the reference model.
    rst = 1'b0;
    btn = '0;
    f1  = '0;
    f2  = '0;
    model_reset();
    tick(1);
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int f = 0; f < N; f++)
        if ($urandom_range(15) == 0) btn[f] = ~btn[f];
      if ($urandom_range(31) == 0) f1 = floor_t'($urandom_range(15));
      if ($urandom_range(31) == 0) f2 = floor_t'($urandom_range(15));
      model_step();
      tick(1);
      chk($sformatf("rnd%0d_valid", c), req_valid, m_valid);
      chk($sformatf("rnd%0d_new", c), req_new, m_new);
      chk($sformatf("rnd%0d_pend", c), pending, m_pend);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hall_call_encoder.md
Name: hall_call_encoder

Overview:
- Upstream stage of the two-car elevator system.
- Synchronises and debounces the per-floor hall call buttons, and latches each valid call as pending.
- Serialises pending calls into single-cycle req_valid/req_new pulses for the scheduler. The scheduler has no ready signal, so each issued call is a fire-and-forget pulse.
- Retires a pending call when either car reports that floor.

Parameters:
NUM_FLOORS, 16, number of hall buttons (2..16). Floor index width is fixed at 4.
DB_CYCLES, 4, number of consecutive stable samples required before a debounced level changes (1..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (asserts immediately, releases on clk edge)
btn  input  NUM_FLOORS  raw hall buttons, asynchronous to clk, active-high
floor_l1  input  4  current floor of car 1
floor_l2  input  4  current floor of car 2
req_valid  output  1  one-cycle pulse: new call on req_new
req_new  output  4  floor index of issued call; valid only while req_valid=1
pending  output  NUM_FLOORS  per-floor outstanding-call flags (drives hall lamps)

Behaviour:
- Reset (rst=0) clears all state and outputs: req_valid=0, req_new=0, pending=0, issued=0, sync flops=0, debounced levels=0, debounce counters=0, scan pointer=0. A reset mid-operation discards all calls, including ones already issued.
- Synchroniser: two flops per button.
- Debounce, per floor:
  - 8-bit counter, cleared whenever the synchronised value equals the debounced level.
  - Otherwise it increments. On the edge where it would reach DB_CYCLES, the debounced level takes the synchronised value and the counter clears.
  - Glitches shorter than DB_CYCLES samples never change the level.
- Pending set: a debounced rising edge sets pending[f], unless pending[f] is already 1 (presses while pending are ignored). A falling edge has no effect.
- Pending clear: pending[f] and issued[f] clear when floor_l1==f or floor_l2==f.
  - Clear beats set in the same cycle, so a press at the floor where a car stands is ignored.
  - Values of floor_lx >= NUM_FLOORS clear nothing.
- Issue arbiter:
  - Each cycle, searches candidates = pending & ~issued & ~at_car, starting at the scan pointer and wrapping at NUM_FLOORS-1 to 0.
  - If a candidate f is found: on the next edge req_valid=1, req_new=f, issued[f]=1, pointer=(f+1) mod NUM_FLOORS.
  - Otherwise req_valid=0, and req_new and the pointer hold.
  - At most one issue per cycle. Back-to-back pulses are allowed.
- Round-robin guarantee: each candidate is issued within NUM_FLOORS cycles.
- Each call is issued exactly once per pending lifetime. A re-press after retirement creates a new call.
- Latency:
  - btn rising before edge 0 reaches sync2 at edge 1.
  - Debounced level rises at edge DB_CYCLES+1.
  - pending at edge DB_CYCLES+2.
  - req_valid high for the cycle after edge DB_CYCLES+3 (edge 7 for the default DB_CYCLES=4).
- Outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: FLOOR_W=4 and the floor_t typedef (shared with the scheduler, FIFO and FSM); DB_CNT_W=8.
- One natural sub-module: call_debouncer (single-bit sync + debounce + rising-edge pulse), instantiated NUM_FLOORS times with generate. The arbiter and pending logic stay in the parent.

Test Plan:
- Reset: hold rst=0 with btn=16'hFFFF -> all outputs 0. Release rst, btn=0 -> req_valid stays 0 for 20 cycles.
- Single press: btn[5] held from before edge 0, cars at floor 0 -> pending[5]=1 after edge 6; req_valid=1, req_new=5 for exactly one cycle after edge 7; no re-issue.
- Glitch rejection: btn[3] high for 3 cycles then low (DB_CYCLES=4) -> pending[3] never set, req_valid never asserted.
- Round-robin: floors 2, 9 and 14 become pending in the same cycle with pointer=10 -> issues in order 14, 2, 9 on consecutive cycles.
- Retire and re-press: floor 5 issued, then floor_l2=5 -> pending[5]=0. Release and re-press btn[5] -> a second req_valid with req_new=5. A press while a car sits at floor 5 -> no pending, no issue.
- Reset mid-operation: pending=16'h0104 with issued set; pulse rst=0 for 1 cycle -> pending=0 and no further req_valid until new presses.
